// File: rtl/serial_negate_multi.sv
// serial_negate_multi
// Multi-lane, bit-serial two's-complement unit. Each lane receives one bit per
// valid cycle, LSB first, in fixed-length words of WIDTH bits. All lanes share
// framing (start, valid) and the per-word mode. Negation uses the serial rule
// "copy bits up to and including the first 1, then invert the rest", so each
// lane only needs to remember whether a 1 has been seen yet.
// All outputs are registered, and the latency is exactly one cycle.
module serial_negate_multi #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic [1:0]       mode,
  input  logic [LANES-1:0] neg_en,
  input  logic [LANES-1:0] i,
  output logic [LANES-1:0] y,
  output logic             out_valid,
  output logic             out_last,
  output logic [LANES-1:0] ovf,
  output logic             err
);

  // Counter width is clog2(WIDTH). It is clamped to 1 so a degenerate
  // parameter still elaborates.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_NEGATE = 2'b01;
  localparam logic [1:0] MODE_COND   = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [LANES-1:0] seen_q,  seen_d;
  logic [LANES-1:0] neg_q,   neg_d;
  logic [LANES-1:0] y_q,     y_d;
  logic             vld_q,   vld_d;
  logic             last_q,  last_d;
  logic [LANES-1:0] ovf_q,   ovf_d;
  logic             err_q,   err_d;

  // Framing decode, shared by every lane.
  logic             start;
  logic             accept;
  logic             at_last;
  logic [CW-1:0]    idx;
  logic [LANES-1:0] new_neg;
  logic [LANES-1:0] neg_eff;
  logic [LANES-1:0] seen_eff;

  // Decode start/accept and the effective per-lane controls for this bit.
  // On a start bit the freshly computed negate mask and a cleared seen_one
  // apply immediately, so that bit 0 is handled with the new word's settings.
  always_comb begin
    start    = in_valid & in_start;
    accept   = in_valid & (in_start | (state_q == ACTIVE));
    idx      = start ? '0 : cnt_q;
    at_last  = accept & (idx == LAST_IDX);
    new_neg  = '0;
    for (int l = 0; l < LANES; l++) begin
      new_neg[l] = (mode == MODE_NEGATE) | ((mode == MODE_COND) & neg_en[l]);
    end
    neg_eff  = start ? new_neg : neg_q;
    seen_eff = start ? '0 : seen_q;
  end

  // Next-state logic: word FSM, bit counter, per-lane transform and flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    neg_d   = neg_q;
    y_d     = y_q;
    vld_d   = accept;
    last_d  = at_last;
    ovf_d   = '0;
    // An in_start while a word is open abandons that word. A valid bit with no
    // word open is an orphan and is dropped. Both cases count as framing errors.
    err_d   = (start & (state_q == ACTIVE)) |
              (in_valid & ~in_start & (state_q == IDLE));

    if (start) begin
      neg_d = new_neg;
    end

    if (accept) begin
      y_d    = i ^ (neg_eff & seen_eff);
      seen_d = seen_eff | i;
      if (at_last) begin
        // Only an input of 100..0 still has no earlier 1 when its MSB arrives.
        // Negating that value cannot be represented, so it is flagged here.
        ovf_d   = neg_eff & i & ~seen_eff;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d   = idx + CW'(1);
        state_d = ACTIVE;
      end
    end
  end

  // State and output registers, cleared asynchronously by r_n.
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= '0;
      neg_q   <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      neg_q   <= neg_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign y         = y_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_serial_negate_multi.sv
// Testbench for serial_negate_multi: directed scenarios plus randomized words,
// checked against an arithmetic reference model of whole-word negation.
module tb_serial_negate_multi;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int DW    = LANES * WIDTH;

  logic             t_clk = 1'b0;
  logic             r_n;
  logic             in_valid;
  logic             in_start;
  logic [1:0]       mode;
  logic [LANES-1:0] neg_en;
  logic [LANES-1:0] i;
  logic [LANES-1:0] y;
  logic             out_valid;
  logic             out_last;
  logic [LANES-1:0] ovf;
  logic             err;

  int n_pass  = 0;
  int n_total = 0;

  // Results captured from one word sent through run_word.
  logic [DW-1:0]    cap_word;
  logic [LANES-1:0] cap_ovf;
  int cap_vcnt, cap_last_pos, cap_last_cnt, cap_err_cnt, cap_stall_bad, cap_ovf_bad;

  serial_negate_multi #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .t_clk(t_clk), .r_n(r_n), .in_valid(in_valid), .in_start(in_start),
    .mode(mode), .neg_en(neg_en), .i(i), .y(y), .out_valid(out_valid),
    .out_last(out_last), .ovf(ovf), .err(err)
  );

  always #5 t_clk = ~t_clk;

  // Reference model: whole-word arithmetic, one lane at a time.
  function automatic bit lane_neg(input logic [1:0] md, input logic [LANES-1:0] ne, input int l);
    return (md == 2'b01) || (md == 2'b10 && ne[l] == 1'b1);
  endfunction

  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] data, input logic [1:0] md,
                                              input logic [LANES-1:0] ne);
    logic [DW-1:0] r;
    int unsigned x, v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      x = int'(data[l*WIDTH +: WIDTH]);
      v = lane_neg(md, ne, l) ? (((1 << WIDTH) - x) % (1 << WIDTH)) : x;
      r[l*WIDTH +: WIDTH] = WIDTH'(v);
    end
    return r;
  endfunction

  function automatic logic [LANES-1:0] model_ovf(input logic [DW-1:0] data, input logic [1:0] md,
                                                 input logic [LANES-1:0] ne);
    logic [LANES-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      r[l] = lane_neg(md, ne, l) && (int'(data[l*WIDTH +: WIDTH]) == (1 << (WIDTH - 1)));
    return r;
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic drive(input logic v, input logic st, input logic [1:0] md,
                       input logic [LANES-1:0] ne, input logic [LANES-1:0] din);
    in_valid = v; in_start = st; mode = md; neg_en = ne; i = din;
    @(posedge t_clk);
    #1;
  endtask

  // Send one word (optionally stalling before bit stall_at and scrambling
  // mode/neg_en after bit 0) and capture what comes out.
  task automatic run_word(input logic [DW-1:0] data, input logic [1:0] md, input logic [LANES-1:0] ne,
                          input int stall_at, input int stall_len, input bit scramble);
    logic [LANES-1:0] bits, y_prev;
    logic [1:0]       m;
    logic [LANES-1:0] n;
    cap_word = '0; cap_ovf = '0; cap_vcnt = 0; cap_last_pos = -1; cap_last_cnt = 0;
    cap_err_cnt = 0; cap_stall_bad = 0; cap_ovf_bad = 0;
    for (int b = 0; b < WIDTH; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          y_prev = y;
          drive(1'b0, 1'($urandom), 2'($urandom), LANES'($urandom), LANES'($urandom));
          if (out_valid !== 1'b0 || out_last !== 1'b0 || y !== y_prev || ovf !== '0) cap_stall_bad++;
          if (err !== 1'b0) cap_err_cnt++;
        end
      end
      for (int l = 0; l < LANES; l++) bits[l] = data[l*WIDTH + b];
      m = (b == 0 || !scramble) ? md : 2'($urandom);
      n = (b == 0 || !scramble) ? ne : LANES'($urandom);
      drive(1'b1, (b == 0), m, n, bits);
      if (err === 1'b1) cap_err_cnt++;
      if (out_valid === 1'b1) begin
        if (cap_vcnt < WIDTH)
          for (int l = 0; l < LANES; l++) cap_word[l*WIDTH + cap_vcnt] = y[l];
        if (out_last === 1'b1) begin
          cap_last_pos = cap_vcnt; cap_last_cnt++; cap_ovf = ovf;
        end else if (ovf !== '0) cap_ovf_bad++;
        cap_vcnt++;
      end
    end
  endtask

  task automatic test_reset();
    r_n = 1'b0; in_valid = 0; in_start = 0; mode = 0; neg_en = 0; i = 0;
    repeat (2) @(posedge t_clk);
    #1;
    n_total++;
    if ({y, out_valid, out_last, ovf, err} !== '0) $display("FAIL reset_state: got %h required 0", {y, out_valid, out_last, ovf, err});
    else n_pass++;
    #2 r_n = 1'b1;
    @(posedge t_clk); #1;
    drive(1'b1, 1'b1, 2'b00, '0, '1);
    drive(1'b1, 1'b0, 2'b00, '0, '1);
    n_total++;
    if (out_valid !== 1'b1 || y !== '1) $display("FAIL pre_reset_word: out_valid %b y %h required 1 f", out_valid, y);
    else n_pass++;
    #3 r_n = 1'b0;
    #1;
    n_total++;
    if ({y, out_valid, out_last, ovf, err} !== '0) $display("FAIL async_reset: got %h required 0", {y, out_valid, out_last, ovf, err});
    else n_pass++;
    @(posedge t_clk); #3 r_n = 1'b1;
    @(posedge t_clk); #1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 2'b01, '0, LANES'($urandom));
      n_total++;
      if (out_valid !== 1'b0 || err !== 1'b1) $display("FAIL orphan_bit%0d: out_valid %b err %b required 0 1", k, out_valid, err);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 2'b00, '0, '0);
    n_total++;
    if (err !== 1'b0) $display("FAIL err_pulse_clear: err %b required 0", err);
    else n_pass++;
  endtask

  task automatic test_negate();
    logic [DW-1:0] d;
    d = {LANES{8'h05}};
    run_word(d, 2'b01, '0, -1, 0, 1'b0);
    n_total++;
    if (cap_word !== model_out(d, 2'b01, '0)) $display("FAIL negate_word: got %h required %h", cap_word, model_out(d, 2'b01, '0));
    else n_pass++;
    n_total++;
    if (cap_vcnt != WIDTH || cap_last_pos != WIDTH-1 || cap_last_cnt != 1)
      $display("FAIL negate_framing: valids %0d last_pos %0d lasts %0d required %0d %0d 1", cap_vcnt, cap_last_pos, cap_last_cnt, WIDTH, WIDTH-1);
    else n_pass++;
    n_total++;
    if (cap_ovf !== '0 || cap_ovf_bad != 0 || cap_err_cnt != 0)
      $display("FAIL negate_flags: ovf %b stray_ovf %0d errs %0d required 0 0 0", cap_ovf, cap_ovf_bad, cap_err_cnt);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] d;
    d = {8'h7F, 8'h01, 8'h00, 8'h80};
    run_word(d, 2'b01, '0, -1, 0, 1'b0);
    n_total++;
    if (cap_word !== model_out(d, 2'b01, '0)) $display("FAIL overflow_word: got %h required %h", cap_word, model_out(d, 2'b01, '0));
    else n_pass++;
    n_total++;
    if (cap_ovf !== model_ovf(d, 2'b01, '0) || cap_ovf_bad != 0)
      $display("FAIL overflow_flag: ovf %b stray %0d required %b 0", cap_ovf, cap_ovf_bad, model_ovf(d, 2'b01, '0));
    else n_pass++;
  endtask

  task automatic test_conditional();
    logic [DW-1:0] d;
    d = {LANES{8'h0C}};
    run_word(d, 2'b10, 4'b0101, -1, 0, 1'b1);
    n_total++;
    if (cap_word !== model_out(d, 2'b10, 4'b0101)) $display("FAIL conditional_word: got %h required %h", cap_word, model_out(d, 2'b10, 4'b0101));
    else n_pass++;
    n_total++;
    if (cap_ovf !== '0 || cap_last_pos != WIDTH-1) $display("FAIL conditional_last: ovf %b last_pos %0d required 0 %0d", cap_ovf, cap_last_pos, WIDTH-1);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [DW-1:0] d;
    d = {LANES{8'h05}};
    run_word(d, 2'b01, '0, 4, 3, 1'b0);
    n_total++;
    if (cap_stall_bad != 0) $display("FAIL stall_hold: bad stall cycles %0d required 0", cap_stall_bad);
    else n_pass++;
    n_total++;
    if (cap_word !== model_out(d, 2'b01, '0)) $display("FAIL stall_word: got %h required %h", cap_word, model_out(d, 2'b01, '0));
    else n_pass++;
    n_total++;
    if (cap_vcnt != WIDTH || cap_last_pos != WIDTH-1 || cap_last_cnt != 1)
      $display("FAIL stall_framing: valids %0d last_pos %0d lasts %0d required %0d %0d 1", cap_vcnt, cap_last_pos, cap_last_cnt, WIDTH, WIDTH-1);
    else n_pass++;
  endtask

  task automatic test_restart_pass();
    logic [DW-1:0] d;
    int bad_last;
    bad_last = 0;
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, (b == 0), 2'b01, '0, LANES'($urandom));
      if (out_last !== 1'b0 || err !== 1'b0) bad_last++;
    end
    n_total++;
    if (bad_last != 0) $display("FAIL restart_prefix: bad cycles %0d required 0", bad_last);
    else n_pass++;
    d = {LANES{8'h3C}};
    run_word(d, 2'b00, '1, -1, 0, 1'b0);
    n_total++;
    if (cap_err_cnt != 1) $display("FAIL restart_err: err pulses %0d required 1", cap_err_cnt);
    else n_pass++;
    n_total++;
    if (cap_word !== model_out(d, 2'b00, '1) || cap_ovf !== '0)
      $display("FAIL restart_word: got %h ovf %b required %h 0", cap_word, cap_ovf, model_out(d, 2'b00, '1));
    else n_pass++;
    n_total++;
    if (cap_last_cnt != 1 || cap_last_pos != WIDTH-1) $display("FAIL restart_last: lasts %0d pos %0d required 1 %0d", cap_last_cnt, cap_last_pos, WIDTH-1);
    else n_pass++;
    drive(1'b0, 1'b0, 2'b00, '0, '0);
    n_total++;
    if (err !== 1'b0 || out_valid !== 1'b0) $display("FAIL restart_idle: err %b out_valid %b required 0 0", err, out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0]    d;
    logic [1:0]       md;
    logic [LANES-1:0] ne;
    int sa, sl;
    for (int w = 0; w < 30; w++) begin
      for (int l = 0; l < LANES; l++)
        d[l*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? WIDTH'(1 << (WIDTH-1)) : WIDTH'($urandom);
      md = 2'($urandom);
      ne = LANES'($urandom);
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WIDTH-1)) : -1;
      sl = int'($urandom_range(1, 3));
      run_word(d, md, ne, sa, sl, 1'b1);
      n_total++;
      if (cap_word !== model_out(d, md, ne)) $display("FAIL random_word%0d: got %h required %h (mode %b en %b)", w, cap_word, model_out(d, md, ne), md, ne);
      else n_pass++;
      n_total++;
      if (cap_ovf !== model_ovf(d, md, ne) || cap_ovf_bad != 0)
        $display("FAIL random_ovf%0d: got %b stray %0d required %b", w, cap_ovf, cap_ovf_bad, model_ovf(d, md, ne));
      else n_pass++;
      n_total++;
      if (cap_last_cnt != 1 || cap_last_pos != WIDTH-1 || cap_err_cnt != 0 || cap_stall_bad != 0)
        $display("FAIL random_framing%0d: lasts %0d pos %0d errs %0d stalls %0d required 1 %0d 0 0", w, cap_last_cnt, cap_last_pos, cap_err_cnt, cap_stall_bad, WIDTH-1);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 2'b00, '0, '0);
    n_total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) $display("FAIL final_idle: out_valid %b out_last %b required 0 0", out_valid, out_last);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_negate();
    test_overflow();
    test_conditional();
    test_stall();
    test_restart_pass();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
